// File: rtl/reg_file_pkg.sv
// Shared CPU register-file types and sizing constants.
// The control unit, the ALU and the register file all use these types.
package reg_file_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef reg_data_t         reg_array_t [DEPTH];

    // A write lands only when control requests it, memory is not
    // stalling, and reset is not overriding the edge.
    function automatic logic write_commits(input logic write,
                                           input logic busywait,
                                           input logic reset);
        return write & ~busywait & ~reset;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: one write port and two read ports.
// The CPU control/datapath drives it through the master modport.
// The register file serves it through the slave modport.
interface reg_file_if;
    import reg_file_pkg::*;

    reg_data_t in;
    reg_addr_t inaddress;
    logic      write;
    logic      busywait;
    reg_addr_t out1address;
    reg_addr_t out2address;
    reg_data_t out1;
    reg_data_t out2;

    modport master (
        output in, inaddress, write, busywait, out1address, out2address,
        input  out1, out2
    );

    modport slave (
        input  in, inaddress, write, busywait, out1address, out2address,
        output out1, out2
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port.
// The port selects the stored register by address. It can optionally
// forward write data that commits this cycle to the same register.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  reg_array_t regs,
    input  reg_addr_t  addr,
    input  logic       commit,
    input  reg_addr_t  waddr,
    input  reg_data_t  wdata,
    output reg_data_t  data
);

    // Select the stored value, then let a matching committing write override it.
    always_comb begin
        // NOTE: assign the output on every path before any conditional override so no latch is inferred.
        data = regs[addr];
        if (BYPASS && commit && (addr == waddr)) begin
            data = wdata;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Eight-entry, 8-bit CPU register file.
// It has two combinational read ports and one synchronous write port.
// Writes are gated by the write strobe and frozen while memory stalls.
// The optional bypass forwards a committing write to a matching read port.
module reg_file
    import reg_file_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input logic       clk,
    input logic       reset,
    reg_file_if.slave bus
);

    reg_array_t regs;
    logic       commit;

    assign commit = write_commits(bus.write, bus.busywait, reset);

    // Storage update: synchronous clear has priority over the single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array needs a real reset because software expects every register to read zero afterwards, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: use non-blocking assignments for state so every register samples pre-edge values.
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.inaddress] <= bus.in;
        end
    end

    // Flag an unknown write strobe or write address whenever a write could commit.
    always_ff @(posedge clk) begin
        if (!reset && (bus.busywait === 1'b0)) begin
            assert (!$isunknown({bus.write, bus.inaddress}));
        end
    end

    reg_read_port #(.BYPASS(BYPASS)) u_port1 (
        .regs   (regs),
        .addr   (bus.out1address),
        .commit (commit),
        .waddr  (bus.inaddress),
        .wdata  (bus.in),
        .data   (bus.out1)
    );

    reg_read_port #(.BYPASS(BYPASS)) u_port2 (
        .regs   (regs),
        .addr   (bus.out2address),
        .commit (commit),
        .waddr  (bus.inaddress),
        .wdata  (bus.in),
        .data   (bus.out2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
// Two instances, one with BYPASS=0 and one with BYPASS=1, receive identical
// stimulus. A behavioural array model predicts every read value.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_file_if bus0 ();
    reg_file_if bus1 ();

    reg_file #(.BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    reg_file #(.BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    // Reference state and the currently driven stimulus.
    reg_data_t model [DEPTH];
    logic      cur_reset, cur_write, cur_busy;
    reg_addr_t cur_waddr, cur_a1, cur_a2;
    reg_data_t cur_data;

    task automatic check(input string tag, input reg_data_t obs, input reg_data_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wr, input logic bw,
                         input reg_addr_t wa, input reg_data_t d,
                         input reg_addr_t a1, input reg_addr_t a2);
        cur_reset = rst; cur_write = wr; cur_busy = bw;
        cur_waddr = wa;  cur_data = d;   cur_a1 = a1; cur_a2 = a2;
        reset = rst;
        bus0.write = wr; bus0.busywait = bw; bus0.inaddress = wa; bus0.in = d;
        bus0.out1address = a1; bus0.out2address = a2;
        bus1.write = wr; bus1.busywait = bw; bus1.inaddress = wa; bus1.in = d;
        bus1.out1address = a1; bus1.out2address = a2;
    endtask

    // Expected read value: the stored value, or the incoming data when the
    // bypass instance sees a write committing to the same address.
    function automatic reg_data_t exp_read(input bit bypass, input reg_addr_t a);
        if (bypass && cur_write && !cur_busy && !cur_reset && (a == cur_waddr))
            return cur_data;
        return model[a];
    endfunction

    task automatic check_ports(input string tag);
        #1;
        check($sformatf("%s/b0/out1", tag), bus0.out1, exp_read(1'b0, cur_a1));
        check($sformatf("%s/b0/out2", tag), bus0.out2, exp_read(1'b0, cur_a2));
        check($sformatf("%s/b1/out1", tag), bus1.out1, exp_read(1'b1, cur_a1));
        check($sformatf("%s/b1/out2", tag), bus1.out2, exp_read(1'b1, cur_a2));
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_reset) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (cur_write && !cur_busy) begin
            model[cur_waddr] = cur_data;
        end
        #1;
    endtask

    // Read every register through both ports with no write pending.
    task automatic scan(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, reg_addr_t'(a), reg_addr_t'(DEPTH - 1 - a));
            check_ports($sformatf("%s/r%0d", tag, a));
        end
    endtask

    task automatic write_reg(input reg_addr_t wa, input reg_data_t d);
        drive(1'b0, 1'b1, 1'b0, wa, d, '0, '0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;

        // Initial reset clears everything.
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        scan("init_reset");

        // Fill with 0xAA, then pulse reset for one cycle.
        for (int i = 0; i < DEPTH; i++) write_reg(reg_addr_t'(i), 8'hAA);
        scan("fill_aa");
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        scan("reset_pulse");
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'd4, 3'd4);
        #1;
        check("reset_r4_const", bus0.out1, 8'h00);

        // Basic write/read on both ports, including both ports on one register.
        write_reg(3'd5, 8'h3C);
        write_reg(3'd2, 8'hC3);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'd5, 3'd2);
        check_ports("wr_5_2");
        check("r5_const", bus0.out1, 8'h3C);
        check("r2_const", bus0.out2, 8'hC3);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'd5, 3'd5);
        check_ports("both_r5");
        check("both_r5_const", bus1.out2, 8'h3C);

        // Stall: a write held for three cycles must not land, then lands once.
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 1'b1, 3'd4, 8'h55, 3'd4, 3'd4);
            check_ports($sformatf("stall_before%0d", c));
            tick();
            check_ports($sformatf("stall_after%0d", c));
            check($sformatf("stall_r4_%0d", c), bus1.out1, 8'h00);
        end
        drive(1'b0, 1'b1, 1'b0, 3'd4, 8'h55, 3'd4, 3'd4);
        check_ports("stall_release");
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'd4, 3'd4);
        #1;
        check("stall_r4_done", bus0.out1, 8'h55);
        scan("stall_one_write");

        // Reset wins over a simultaneous write.
        drive(1'b1, 1'b1, 1'b0, 3'd1, 8'hFF, 3'd1, 3'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'd1, 3'd1);
        #1;
        check("reset_vs_write", bus0.out1, 8'h00);
        scan("reset_vs_write");

        // Reset during a held stalled write, then the write commits after release.
        drive(1'b0, 1'b1, 1'b1, 3'd7, 8'h9E, 3'd7, 3'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 3'd7, 8'h9E, 3'd7, 3'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 3'd7, 8'h9E, 3'd7, 3'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'd7, 3'd0);
        #1;
        check("reset_mid_stall", bus0.out1, 8'h9E);

        // Bypass versus stored-value reads of a write in flight.
        write_reg(3'd3, 8'h11);
        drive(1'b0, 1'b1, 1'b0, 3'd3, 8'h22, 3'd3, 3'd2);
        check_ports("bypass_before");
        check("bypass_on_before", bus1.out1, 8'h22);
        check("bypass_off_before", bus0.out1, 8'h11);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'd3, 3'd3);
        #1;
        check("bypass_on_after", bus1.out1, 8'h22);
        check("bypass_off_after", bus0.out1, 8'h22);

        // Shifter feed: operands out, shifted result written back to r6.
        write_reg(3'd0, 8'h81);
        write_reg(3'd1, 8'h03);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, 3'd1);
        check_ports("shift_operands");
        check("shift_in", bus0.out1, 8'h81);
        check("shift_amt", bus0.out2, 8'h03);
        write_reg(3'd6, 8'(8'h81 << 3));
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'd6, 3'd6);
        #1;
        check("shift_result", bus0.out1, 8'h08);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) == 0),
                  1'($urandom),
                  ($urandom_range(0, 3) == 0),
                  reg_addr_t'($urandom),
                  reg_data_t'($urandom),
                  reg_addr_t'($urandom),
                  reg_addr_t'($urandom));
            check_ports($sformatf("rand%0d_pre", n));
            tick();
            check_ports($sformatf("rand%0d_post", n));
        end
        scan("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Eight-entry, 8-bit register file for the single-cycle CPU: two combinational read ports supply DATA1/DATA2 to the ALU (and therefore to the logical shifter), and one synchronous write port accepts the ALU/shifter result or memory read data at write-back. Writes are gated by the control unit's WRITE strobe and frozen while the memory subsystem asserts BUSYWAIT. An optional write-through bypass lets a register being written appear on a read port in the same cycle.

## Interface
- DATA_W, 8, width of each register and of all data ports
- ADDR_W, 3, register address width; depth is 2**ADDR_W (8)
- BYPASS, 0, 1 = read port returns IN when its address matches a write committing this cycle; 0 = read returns stored value
- CLK  input  1  system clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high; clears all registers on the rising edge where it is sampled high
- IN  input  DATA_W  write data (ALU result or memory read data, selected upstream)
- INADDRESS  input  ADDR_W  write destination register
- WRITE  input  1  write enable from control unit
- BUSYWAIT  input  1  memory stall; high blocks any write
- OUT1ADDRESS  input  ADDR_W  read port 1 address (operand RT)
- OUT2ADDRESS  input  ADDR_W  read port 2 address (operand RS)
- OUT1  output  DATA_W  read port 1 data (to ALU DATA1 / shifter IN)
- OUT2  output  DATA_W  read port 2 data (to operand mux / shift amount)

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits; register 0 is ordinary (not hardwired to zero).
- Write commit condition: WRITE=1 and BUSYWAIT=0 and RESET=0, sampled at CLK rising edge; register[INADDRESS] <= IN.
- RESET has priority over any write in the same cycle: all registers become 0, the pending write is discarded.
- WRITE=1 with BUSYWAIT=1: no register changes; the write is not queued; control holds WRITE/IN/INADDRESS until BUSYWAIT falls, and the write commits on the first edge with BUSYWAIT=0.
- Reads: OUTn = register[OUTnADDRESS], combinational, no clock involvement; both ports may address the same register.
- Bypass (BYPASS=1): if commit condition is true this cycle and OUTnADDRESS == INADDRESS, OUTn = IN; otherwise stored value. With BYPASS=0 the read shows the old value until after the edge.
- Widths: no arithmetic; addresses are exact width, so every address value is valid (no out-of-range case).
- X on WRITE or INADDRESS while BUSYWAIT=0 is a control bug; simulation asserts flag it.

## Timing
- Reset value: all registers 0; therefore OUT1 = OUT2 = 0 in the cycle after RESET is sampled high (any address).
- Write latency: value written at edge N is visible on a matching read port immediately after edge N (same cycle with BYPASS=1).
- Read latency: zero cycles, purely combinational from address/storage.
- Reset mid-operation: RESET asserted while BUSYWAIT=1 and a write is held still clears everything; the held write commits after RESET falls only if WRITE is still high and BUSYWAIT is 0.
- Single write port: at most one register changes per edge.
- No output is registered; OUT1/OUT2 settle within the same cycle as the address change.

## Structure
- Shared cpu_pkg: DATA_W, ADDR_W constants, reg_addr_t and reg_data_t typedefs used by control unit, ALU and this block.
- One sub-module natural: reg_read_port (address decode + optional bypass compare/mux), instantiated twice; storage array and write logic stay in reg_file.

## Test plan
- Reset: write 0xAA to all 8 registers, pulse RESET one cycle -> every register reads 0x00 on both ports.
- Write/read: write 0x3C to r5, 0xC3 to r2 -> OUT1ADDRESS=5 gives 0x3C, OUT2ADDRESS=2 gives 0xC3; both ports at r5 give 0x3C.
- Stall: WRITE=1, INADDRESS=4, IN=0x55, BUSYWAIT=1 for 3 cycles -> r4 stays 0x00; BUSYWAIT falls -> r4=0x55 after next edge, exactly one write.
- Reset vs write: RESET=1 and WRITE=1, IN=0xFF, INADDRESS=1 same edge -> r1 reads 0x00.
- Bypass: BYPASS=1, r3=0x11, write IN=0x22 to r3 with OUT1ADDRESS=3 -> OUT1=0x22 before the edge; BYPASS=0 -> OUT1=0x11 before, 0x22 after.
- Shifter feed: r0=0x81, r1=0x03 -> OUT1=0x81 to shifter IN, OUT2=0x03 as shift amount; downstream left shift result 0x08 written back to r6 reads 0x08.
